// File: rtl/ni_tx_2ph.sv
// ni_tx_2ph: network-interface transmitter from a local flit FIFO onto a
// 2-phase bundled-data link; Data_o leads each req_o toggle by SETUP_CYCLES.
module ni_tx_2ph #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   s_ready,
    output logic                   req_o,
    output logic [WIDTH-1:0]       Data_o,
    input  logic                   ack_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   proto_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(SETUP_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic [TW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   ready_en;
    logic                   push;
    logic                   pop;

    // ready_en keeps s_ready low until the first edge after reset release
    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign s_ready = ready_en && (fifo_count_o < FULL);
    assign push    = s_valid && s_ready;
    assign pop     = (state == IDLE) && (fifo_count_o != '0);
    assign busy_o  = (state != IDLE) || (fifo_count_o != '0);

    // flit storage, written on each accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr         <= '0;
            rptr         <= '0;
            fifo_count_o <= '0;
            ready_en     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count_o <= fifo_count_o + CW'(1);
            end else if (pop && !push) begin
                fifo_count_o <= fifo_count_o - CW'(1);
            end
        end
    end

    // ack_i is asynchronous; only this chain ever samples it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end

    // handshake FSM: launch data, wait the setup margin, toggle req, await ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            req_o  <= 1'b0;
            Data_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        Data_o <= mem[rptr];
                        cnt    <= SETUP_LOAD;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        req_o <= ~req_o;
                        state <= WAIT_ACK;
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (ack_s == req_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sticky flag: an ack phase change while no flit is outstanding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err_o <= 1'b0;
        end else if ((state != WAIT_ACK) && (ack_s != req_o)) begin
            proto_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ni_tx_2ph.sv
// tb_ni_tx_2ph: scoreboard bench for ni_tx_2ph with a router ack model,
// directed handshake/boundary cases and a randomized flit run.
module tb_ni_tx_2ph;

    localparam int WIDTH        = 32;
    localparam int DEPTH        = 4;
    localparam int SETUP_CYCLES = 2;
    localparam int SYNC_STAGES  = 2;
    localparam int CW           = $clog2(DEPTH) + 1;
    localparam int N_RAND       = 5000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             req_o;
    logic [WIDTH-1:0] Data_o;
    logic             ack_i;
    logic             busy_o;
    logic [CW-1:0]    fifo_count_o;
    logic             proto_err_o;

    int checks   = 0;
    int failures = 0;
    int pushes   = 0;
    int toggles  = 0;
    int man_ack  = 0;
    bit auto_ack = 1'b0;

    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    ni_tx_2ph #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SETUP_CYCLES(SETUP_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .req_o(req_o),
        .Data_o(Data_o),
        .ack_i(ack_i),
        .busy_o(busy_o),
        .fifo_count_o(fifo_count_o),
        .proto_err_o(proto_err_o)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // inputs are stable from +2 after an edge through the next edge,
    // so the negedge sees exactly what the next edge will accept
    always @(negedge clk) begin
        if (reset_n && s_valid && s_ready) begin
            exp_q.push_back(s_data);
            pushes++;
        end
    end

    // router input port model: manual acks on request, automatic acks
    // with random delay; its phase returns to 0 with the shared reset
    initial begin
        int seen;
        int d;
        seen  = 0;
        ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ack_i = 1'b0;
            end else if (man_ack != seen) begin
                seen  = man_ack;
                ack_i = ~ack_i;
            end else if (auto_ack && (req_o !== ack_i)) begin
                if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 20);
                else d = $urandom_range(0, 1);
                repeat (d) @(negedge clk);
                if (reset_n) ack_i = req_o;
            end
        end
    end

    // output monitor: every req_o toggle delivers the next expected flit,
    // Data_o held for the setup margin before it and until the ack settles
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] hold_val;
    logic             prev_req = 1'b0;
    bit               hold     = 1'b0;
    bit               hold_bad = 1'b0;
    bit               ack_seen = 1'b0;
    bit               setup_bad;
    int               hold_cnt = 0;

    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            exp_q.delete();
            hist.delete();
            hold     = 1'b0;
            prev_req = 1'b0;
        end else begin
            hist.push_front(Data_o);
            if (hist.size() > SETUP_CYCLES + 1) void'(hist.pop_back());
            if (hold) begin
                if (Data_o !== hold_val) hold_bad = 1'b1;
                if (ack_seen) begin
                    hold_cnt--;
                    if (hold_cnt == 0) begin
                        hold = 1'b0;
                        check("data_stable_wait", 64'(hold_bad), 64'd0);
                    end
                end else if (ack_i === req_o) begin
                    ack_seen = 1'b1;
                    hold_cnt = SYNC_STAGES;
                end
            end
            if (req_o !== prev_req) begin
                prev_req = req_o;
                toggles++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL flit_data: req toggle with Data_o=%h, none expected",
                             Data_o);
                end else begin
                    check("flit_data", 64'(Data_o), 64'(exp_q.pop_front()));
                end
                setup_bad = 1'b0;
                foreach (hist[i]) if (hist[i] !== Data_o) setup_bad = 1'b1;
                check("data_stable_setup", 64'(setup_bad), 64'd0);
                hold     = 1'b1;
                hold_val = Data_o;
                hold_bad = 1'b0;
                ack_seen = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acc;
        int   t0;
        int   sent;
        logic rdy;
        logic r0;

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) tick();
        check("rst_count", 64'(fifo_count_o), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_data", 64'(Data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_proto", 64'(proto_err_o), 64'd0);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(s_ready), 64'd0);
        tick();
        check("ready_after_release", 64'(s_ready), 64'd1);

        // single flit latency
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        tick();
        s_valid = 1'b0;
        check("t1_count_e0", 64'(fifo_count_o), 64'd1);
        tick();
        check("t1_data_e1", 64'(Data_o), 64'h0000_0000_A5A5_0001);
        check("t1_req_e1", 64'(req_o), 64'd0);
        tick();
        check("t1_req_e2", 64'(req_o), 64'd0);
        tick();
        check("t1_req_e3", 64'(req_o), 64'd1);
        man_ack++;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_o && n < 10);
        check("t1_idle_latency", 64'((n <= SYNC_STAGES + 1) && !busy_o), 64'd1);

        // back-to-back burst with acks withheld
        t0      = toggles;
        acc     = 0;
        n       = 0;
        s_valid = 1'b1;
        s_data  = 32'd1;
        while (acc < 5 && n < 20) begin
            rdy = s_ready;
            tick();
            n++;
            if (rdy) begin
                acc++;
                s_data = WIDTH'(acc + 1);
            end
        end
        check("burst_accepted", 64'(acc), 64'd5);
        check("burst_ready_low", 64'(s_ready), 64'd0);
        check("burst_count_full", 64'(fifo_count_o), 64'(DEPTH));
        repeat (4) tick();
        check("burst_still_full", 64'(fifo_count_o), 64'(DEPTH));
        check("burst_outstanding", 64'(req_o !== ack_i), 64'd1);

        // full boundary: pop edge takes no push, following edge does
        man_ack++;
        n = 0;
        while (fifo_count_o == CW'(DEPTH) && n < 20) begin
            tick();
            n++;
        end
        check("full_no_push_on_pop", 64'(fifo_count_o), 64'(DEPTH - 1));
        tick();
        check("full_push_next_edge", 64'(fifo_count_o), 64'(DEPTH));
        check("full_ready_low", 64'(s_ready), 64'd0);
        s_valid = 1'b0;

        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_o === ack_i && n < 40) begin
                tick();
                n++;
            end
            check("burst_req_pending", 64'(req_o !== ack_i), 64'd1);
            man_ack++;
            tick();
        end
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        check("burst_toggles", 64'(toggles - t0), 64'd6);
        check("burst_drained", 64'(exp_q.size()), 64'd0);

        // spurious ack while idle
        r0 = req_o;
        man_ack++;
        repeat (SYNC_STAGES) tick();
        check("spur_proto_early", 64'(proto_err_o), 64'd0);
        tick();
        check("spur_proto_set", 64'(proto_err_o), 64'd1);
        check("spur_req_unchanged", 64'(req_o), 64'(r0));
        t0      = toggles;
        s_valid = 1'b1;
        s_data  = 32'hC0DE_0035;
        tick();
        s_valid = 1'b0;
        n = 0;
        while (toggles == t0 && n < 20) begin
            tick();
            n++;
        end
        check("spur_flit_delivered", 64'(toggles - t0), 64'd1);
        tick();
        check("spur_proto_sticky", 64'(proto_err_o), 64'd1);
        reset_n = 1'b0;
        repeat (2) tick();
        check("spur_proto_reset", 64'(proto_err_o), 64'd0);
        reset_n = 1'b1;
        tick();

        // reset in the middle of a handshake
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = WIDTH'(32'h0000_0011 * (k + 1));
            tick();
        end
        s_valid = 1'b0;
        n = 0;
        while (req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("mid_req_high", 64'(req_o), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_req_async", 64'(req_o), 64'd0);
        check("mid_data_async", 64'(Data_o), 64'd0);
        check("mid_count_async", 64'(fifo_count_o), 64'd0);
        check("mid_ready_async", 64'(s_ready), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = 32'h600D_F1A7;
        tick();
        s_valid = 1'b0;
        tick();
        check("post_rst_data", 64'(Data_o), 64'h0000_0000_600D_F1A7);
        repeat (SETUP_CYCLES) tick();
        check("post_rst_req", 64'(req_o), 64'd1);
        man_ack++;
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        check("post_rst_idle", 64'(busy_o), 64'd0);

        // randomized run with the automatic router
        auto_ack = 1'b1;
        t0       = toggles;
        sent     = 0;
        n        = 0;
        while (sent < N_RAND && n < 60000) begin
            if (!s_valid && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = WIDTH'($urandom);
            end
            rdy = s_ready;
            tick();
            n++;
            if (s_valid && rdy) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        check("rand_all_sent", 64'(sent), 64'(N_RAND));
        n = 0;
        while ((busy_o || exp_q.size() != 0 || req_o !== ack_i) && n < 200) begin
            tick();
            n++;
        end
        repeat (SYNC_STAGES + 2) tick();
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_delivered", 64'(toggles - t0), 64'(sent));
        check("rand_idle", 64'(busy_o), 64'd0);
        check("rand_no_proto_err", 64'(proto_err_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
